// File: rtl/channel_ctrl_pkg.sv
// Shared constants for channel_ctrl: opcodes, FSM states, timing reset values.
// Imported by channel_ctrl; holds no logic beyond a lane-to-byte-enable helper.
package channel_ctrl_pkg;

    localparam logic [7:0] OPC_CONF_WR   = 8'h2A;
    localparam logic [7:0] OPC_CHAN_SEL  = 8'h3A;
    localparam logic [7:0] OPC_ADDR_WR   = 8'h3C;
    localparam logic [7:0] OPC_DATA_WR   = 8'h2C;
    localparam logic [7:0] OPC_FLUSH     = 8'h5A;
    localparam logic [7:0] OPC_FLUSH_ALL = 8'h5C;

    localparam logic [7:0] T0H_DEF = 8'd16;
    localparam logic [8:0] T0S_DEF = 9'd60;
    localparam logic [7:0] T1H_DEF = 8'd40;
    localparam logic [8:0] T1S_DEF = 9'd60;

    localparam int         CONF_LEN = 6;
    localparam logic [1:0] LANE_TOP = 2'd3;

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_CONF,
        ST_SEL,
        ST_ADDR,
        ST_DATA,
        ST_SKIP
    } state_e;

    function automatic logic [3:0] lane_byte_en(input logic [1:0] lane);
        lane_byte_en = 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/channel_ctrl.sv
// Command decoder / RAM write sequencer for LED channels; optional CHANNEL_CTRL_AUTO_FLUSH_EN
// pulses done on frame end in DATA. All outputs registered, 1 cycle after the byte strobe.
// No backpressure: every byte strobe is consumed in the cycle it arrives.
module channel_ctrl
    import channel_ctrl_pkg::*;
#(
    parameter int CH_CNT = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              byte_vld_i,
    input  logic [7:0]        byte_data_i,
    input  logic              frame_end_i,
    output logic [7:0]        reg_t0h_time_o,
    output logic [8:0]        reg_t0s_time_o,
    output logic [7:0]        reg_t1h_time_o,
    output logic [8:0]        reg_t1s_time_o,
    output logic [CH_CNT-1:0] ram_wr_en_o,
    output logic [CH_CNT-1:0] ram_wr_done_o,
    output logic [7:0]        ram_wr_addr_o,
    output logic [7:0]        ram_wr_data_o,
    output logic [3:0]        ram_wr_byte_en_o
);

    localparam int CH_W = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;

    state_e state_q, state_d;

    logic [2:0]        conf_cnt_q, conf_cnt_d;
    logic [7:0]        stg_t0h_q, stg_t0h_d;
    logic              stg_t0s8_q, stg_t0s8_d;
    logic [7:0]        stg_t0s_lo_q, stg_t0s_lo_d;
    logic [7:0]        stg_t1h_q, stg_t1h_d;
    logic              stg_t1s8_q, stg_t1s8_d;

    logic [7:0]        t0h_q, t0h_d;
    logic [8:0]        t0s_q, t0s_d;
    logic [7:0]        t1h_q, t1h_d;
    logic [8:0]        t1s_q, t1s_d;

    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic [7:0]        waddr_q, waddr_d;
    logic [1:0]        lane_q, lane_d;

    logic [CH_CNT-1:0] wr_en_q, wr_en_d;
    logic [CH_CNT-1:0] done_q, done_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [3:0]        be_q, be_d;

    logic [CH_CNT-1:0] ch_onehot;

    always_comb begin
        ch_onehot           = '0;
        ch_onehot[ch_sel_q] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_OPCODE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (byte_vld_i) begin
            case (state_q)
                ST_OPCODE: begin
                    case (byte_data_i)
                        OPC_CONF_WR:   state_d = ST_CONF;
                        OPC_CHAN_SEL:  state_d = ST_SEL;
                        OPC_ADDR_WR:   state_d = ST_ADDR;
                        OPC_DATA_WR:   state_d = ST_DATA;
                        OPC_FLUSH,
                        OPC_FLUSH_ALL: state_d = ST_OPCODE;
                        default:       state_d = ST_SKIP;
                    endcase
                end
                ST_CONF: begin
                    if (conf_cnt_q == 3'(CONF_LEN - 1)) begin
                        state_d = ST_OPCODE;
                    end
                end
                ST_SEL,
                ST_ADDR: state_d = ST_OPCODE;
                default: state_d = state_q;
            endcase
        end
        // The coincident byte has already been accounted for above.
        if (frame_end_i) begin
            state_d = ST_OPCODE;
        end
    end

    always_comb begin
        conf_cnt_d   = conf_cnt_q;
        stg_t0h_d    = stg_t0h_q;
        stg_t0s8_d   = stg_t0s8_q;
        stg_t0s_lo_d = stg_t0s_lo_q;
        stg_t1h_d    = stg_t1h_q;
        stg_t1s8_d   = stg_t1s8_q;
        t0h_d        = t0h_q;
        t0s_d        = t0s_q;
        t1h_d        = t1h_q;
        t1s_d        = t1s_q;
        ch_sel_d     = ch_sel_q;
        waddr_d      = waddr_q;
        lane_d       = lane_q;
        wr_en_d      = '0;
        done_d       = '0;
        addr_d       = addr_q;
        data_d       = data_q;
        be_d         = be_q;

        if (byte_vld_i) begin
            case (state_q)
                ST_OPCODE: begin
                    conf_cnt_d = '0;
                    if (byte_data_i == OPC_FLUSH) begin
                        done_d = ch_onehot;
                    end else if (byte_data_i == OPC_FLUSH_ALL) begin
                        done_d = '1;
                    end
                end
                ST_CONF: begin
                    conf_cnt_d = conf_cnt_q + 3'd1;
                    case (conf_cnt_q)
                        3'd0:    stg_t0h_d    = byte_data_i;
                        3'd1:    stg_t0s8_d   = byte_data_i[0];
                        3'd2:    stg_t0s_lo_d = byte_data_i;
                        3'd3:    stg_t1h_d    = byte_data_i;
                        3'd4:    stg_t1s8_d   = byte_data_i[0];
                        default: begin
                            // Last payload byte: publish all four registers at once.
                            t0h_d = stg_t0h_q;
                            t0s_d = {stg_t0s8_q, stg_t0s_lo_q};
                            t1h_d = stg_t1h_q;
                            t1s_d = {stg_t1s8_q, byte_data_i};
                        end
                    endcase
                end
                ST_SEL: begin
                    if (int'({24'd0, byte_data_i}) < CH_CNT) begin
                        ch_sel_d = byte_data_i[CH_W-1:0];
                    end
                end
                ST_ADDR: begin
                    waddr_d = byte_data_i;
                    lane_d  = LANE_TOP;
                end
                ST_DATA: begin
                    wr_en_d = ch_onehot;
                    addr_d  = waddr_q;
                    data_d  = byte_data_i;
                    be_d    = lane_byte_en(lane_q);
                    if (lane_q == 2'd0) begin
                        waddr_d = waddr_q + 8'd1;
                        lane_d  = LANE_TOP;
                    end else begin
                        lane_d  = lane_q - 2'd1;
                    end
                end
                default: ;
            endcase
        end

        // A partial word stays partial; the next DATA frame restarts at the top lane.
        if (frame_end_i && (state_q == ST_DATA)) begin
            lane_d = LANE_TOP;
`ifdef CHANNEL_CTRL_AUTO_FLUSH_EN
            done_d = ch_onehot;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            conf_cnt_q   <= '0;
            stg_t0h_q    <= '0;
            stg_t0s8_q   <= 1'b0;
            stg_t0s_lo_q <= '0;
            stg_t1h_q    <= '0;
            stg_t1s8_q   <= 1'b0;
            t0h_q        <= T0H_DEF;
            t0s_q        <= T0S_DEF;
            t1h_q        <= T1H_DEF;
            t1s_q        <= T1S_DEF;
            ch_sel_q     <= '0;
            waddr_q      <= '0;
            lane_q       <= LANE_TOP;
            wr_en_q      <= '0;
            done_q       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            be_q         <= '0;
        end else begin
            conf_cnt_q   <= conf_cnt_d;
            stg_t0h_q    <= stg_t0h_d;
            stg_t0s8_q   <= stg_t0s8_d;
            stg_t0s_lo_q <= stg_t0s_lo_d;
            stg_t1h_q    <= stg_t1h_d;
            stg_t1s8_q   <= stg_t1s8_d;
            t0h_q        <= t0h_d;
            t0s_q        <= t0s_d;
            t1h_q        <= t1h_d;
            t1s_q        <= t1s_d;
            ch_sel_q     <= ch_sel_d;
            waddr_q      <= waddr_d;
            lane_q       <= lane_d;
            wr_en_q      <= wr_en_d;
            done_q       <= done_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            be_q         <= be_d;
        end
    end

    assign reg_t0h_time_o   = t0h_q;
    assign reg_t0s_time_o   = t0s_q;
    assign reg_t1h_time_o   = t1h_q;
    assign reg_t1s_time_o   = t1s_q;
    assign ram_wr_en_o      = wr_en_q;
    assign ram_wr_done_o    = done_q;
    assign ram_wr_addr_o    = addr_q;
    assign ram_wr_data_o    = data_q;
    assign ram_wr_byte_en_o = be_q;

endmodule

// File: tb/tb_channel_ctrl.sv
// Self-checking bench for channel_ctrl: directed scenarios plus random frames against a frame-level model.
module tb_channel_ctrl;

    localparam int CH = 8;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          byte_vld_i;
    logic [7:0]    byte_data_i;
    logic          frame_end_i;
    logic [7:0]    reg_t0h_time_o;
    logic [8:0]    reg_t0s_time_o;
    logic [7:0]    reg_t1h_time_o;
    logic [8:0]    reg_t1s_time_o;
    logic [CH-1:0] ram_wr_en_o;
    logic [CH-1:0] ram_wr_done_o;
    logic [7:0]    ram_wr_addr_o;
    logic [7:0]    ram_wr_data_o;
    logic [3:0]    ram_wr_byte_en_o;

    always #5 clk_i = ~clk_i;

    channel_ctrl #(.CH_CNT(CH)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .byte_vld_i       (byte_vld_i),
        .byte_data_i      (byte_data_i),
        .frame_end_i      (frame_end_i),
        .reg_t0h_time_o   (reg_t0h_time_o),
        .reg_t0s_time_o   (reg_t0s_time_o),
        .reg_t1h_time_o   (reg_t1h_time_o),
        .reg_t1s_time_o   (reg_t1s_time_o),
        .ram_wr_en_o      (ram_wr_en_o),
        .ram_wr_done_o    (ram_wr_done_o),
        .ram_wr_addr_o    (ram_wr_addr_o),
        .ram_wr_data_o    (ram_wr_data_o),
        .ram_wr_byte_en_o (ram_wr_byte_en_o)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

`ifdef CHANNEL_CTRL_AUTO_FLUSH_EN
    localparam bit AUTO_FLUSH = 1'b1;
`else
    localparam bit AUTO_FLUSH = 1'b0;
`endif

    typedef struct {
        logic [7:0] en;
        logic [7:0] done;
        logic [7:0] addr;
        logic [7:0] data;
        logic [3:0] be;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    bit  mon_on = 1'b0;

    always @(negedge clk_i) begin
        ev_t e;
        if (mon_on && (ram_wr_en_o != '0 || ram_wr_done_o != '0)) begin
            e.en   = ram_wr_en_o;
            e.done = ram_wr_done_o;
            e.addr = ram_wr_addr_o;
            e.data = ram_wr_data_o;
            e.be   = ram_wr_byte_en_o;
            obs_q.push_back(e);
        end
    end

    // Reference model state, updated one whole frame at a time.
    int         m_ch;
    logic [7:0] m_addr;
    int         m_lane;
    logic [7:0] m_t0h, m_t1h;
    logic [8:0] m_t0s, m_t1s;

    task automatic model_reset();
        m_ch = 0; m_addr = 8'h00; m_lane = 3;
        m_t0h = 8'd16; m_t0s = 9'd60; m_t1h = 8'd40; m_t1s = 9'd60;
    endtask

    task automatic model_frame(input logic [7:0] b[$], input bit coinc);
        int   i = 0;
        int   n = b.size();
        int   dpos = -1;
        logic [7:0] op;
        ev_t  e;
        while (i < n) begin
            op = b[i];
            i++;
            case (op)
                8'h2A: begin
                    if (i + 6 <= n) begin
                        m_t0h = b[i];
                        m_t0s = {b[i+1][0], b[i+2]};
                        m_t1h = b[i+3];
                        m_t1s = {b[i+4][0], b[i+5]};
                        i += 6;
                    end else begin
                        i = n;
                    end
                end
                8'h3A: if (i < n) begin
                    if (b[i] < CH) m_ch = int'(b[i]);
                    i++;
                end
                8'h3C: if (i < n) begin
                    m_addr = b[i];
                    m_lane = 3;
                    i++;
                end
                8'h2C: begin
                    dpos = i - 1;
                    while (i < n) begin
                        e.en = 8'(1 << m_ch); e.done = 8'h00;
                        e.addr = m_addr; e.data = b[i]; e.be = 4'(1 << m_lane);
                        exp_q.push_back(e);
                        if (m_lane == 0) begin
                            m_addr = m_addr + 8'd1;
                            m_lane = 3;
                        end else begin
                            m_lane = m_lane - 1;
                        end
                        i++;
                    end
                end
                8'h5A: begin
                    e.en = 8'h00; e.done = 8'(1 << m_ch); e.addr = 8'h00; e.data = 8'h00; e.be = 4'h0;
                    exp_q.push_back(e);
                end
                8'h5C: begin
                    e.en = 8'h00; e.done = 8'hFF; e.addr = 8'h00; e.data = 8'h00; e.be = 4'h0;
                    exp_q.push_back(e);
                end
                default: i = n;
            endcase
        end
        if (dpos >= 0 && !(coinc && dpos == n - 1)) begin
            m_lane = 3;
            if (AUTO_FLUSH) begin
                if (coinc) begin
                    e = exp_q.pop_back();
                    e.done = 8'(1 << m_ch);
                    exp_q.push_back(e);
                end else begin
                    e.en = 8'h00; e.done = 8'(1 << m_ch); e.addr = 8'h00; e.data = 8'h00; e.be = 4'h0;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic fe);
        @(negedge clk_i);
        byte_vld_i  = v;
        byte_data_i = d;
        frame_end_i = fe;
    endtask

    task automatic send_frame(input logic [7:0] b[$], input bit coinc);
        for (int i = 0; i < b.size(); i++) begin
            step(1'b1, b[i], coinc && (i == b.size() - 1));
        end
        if (!coinc || b.size() == 0) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; byte_vld_i = 1'b0; byte_data_i = 8'h00; frame_end_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk_cnt++;
        if ({ram_wr_en_o, ram_wr_done_o} !== 16'h0000)
            $display("FAIL reset_strobes: got en=%h done=%h want 00/00", ram_wr_en_o, ram_wr_done_o);
        else pass_cnt++;
        chk_cnt++;
        if ({reg_t0h_time_o, reg_t0s_time_o, reg_t1h_time_o, reg_t1s_time_o} !== {8'd16, 9'd60, 8'd40, 9'd60})
            $display("FAIL reset_timing: got %0d/%0d/%0d/%0d want 16/60/40/60",
                     reg_t0h_time_o, reg_t0s_time_o, reg_t1h_time_o, reg_t1s_time_o);
        else pass_cnt++;
        chk_cnt++;
        if ({ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o} !== 20'h0)
            $display("FAIL reset_bus: got addr=%h data=%h be=%h want 0", ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o);
        else pass_cnt++;
    endtask

    task automatic test_conf();
        logic [7:0] fq[$];
        logic [7:0] pl[6];
        fq = '{8'h2A, 8'h11, 8'h01, 8'h33};
        send_frame(fq, 1'b0);
        chk_cnt++;
        if ({reg_t0h_time_o, reg_t0s_time_o, reg_t1h_time_o, reg_t1s_time_o} !== {8'd16, 9'd60, 8'd40, 9'd60})
            $display("FAIL conf_cut: got %h/%h/%h/%h want defaults",
                     reg_t0h_time_o, reg_t0s_time_o, reg_t1h_time_o, reg_t1s_time_o);
        else pass_cnt++;
        pl = '{8'h10, 8'h00, 8'h20, 8'h01, 8'h01, 8'hFF};
        step(1'b1, 8'h2A, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, pl[i], 1'b0);
        chk_cnt++;
        if (reg_t0h_time_o !== 8'd16)
            $display("FAIL conf_early: t0h=%h before last byte processed, want 10 (default)", reg_t0h_time_o);
        else pass_cnt++;
        step(1'b0, 8'h00, 1'b1);
        chk_cnt++;
        if ({reg_t0h_time_o, reg_t0s_time_o, reg_t1h_time_o, reg_t1s_time_o} !== {8'h10, 9'h020, 8'h01, 9'h1FF})
            $display("FAIL conf_update: got %h/%h/%h/%h want 10/020/01/1ff",
                     reg_t0h_time_o, reg_t0s_time_o, reg_t1h_time_o, reg_t1s_time_o);
        else pass_cnt++;
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_data_burst();
        logic [7:0] fq[$];
        logic [7:0] d[12];
        logic [7:0] ea;
        fq = '{8'h3A, 8'h02};
        send_frame(fq, 1'b0);
        fq = '{8'h3C, 8'hFE};
        send_frame(fq, 1'b0);
        d = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        step(1'b1, 8'h2C, 1'b0);
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) step(1'b1, d[i], 1'b0);
            else        step(1'b0, 8'h00, 1'b0);
            chk_cnt++;
            if (i == 0) begin
                if (ram_wr_en_o !== 8'h00)
                    $display("FAIL data_opcode_no_write: en=%h want 00", ram_wr_en_o);
                else pass_cnt++;
            end else begin
                ea = 8'hFE + 8'((i - 1) / 4);
                if ({ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o} !==
                    {8'h04, ea, d[i-1], 4'(8 >> ((i - 1) % 4))})
                    $display("FAIL data_write[%0d]: got en=%h addr=%h data=%h be=%h want en=04 addr=%h data=%h be=%h",
                             i - 1, ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o,
                             ea, d[i-1], 4'(8 >> ((i - 1) % 4)));
                else pass_cnt++;
            end
        end
        step(1'b0, 8'h00, 1'b1);
        chk_cnt++;
        if (ram_wr_en_o !== 8'h00 || ram_wr_addr_o !== 8'h00 || ram_wr_data_o !== 8'h77)
            $display("FAIL data_strobe_width: en=%h addr=%h data=%h want en=00 addr=00 data=77 held",
                     ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o);
        else pass_cnt++;
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_chan_sel_flush();
        logic [7:0] fq[$];
        fq = '{8'h3A, 8'h09};
        send_frame(fq, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk_cnt++;
        if ({ram_wr_done_o, ram_wr_en_o} !== 16'h0400)
            $display("FAIL flush_sel: done=%h en=%h want 04/00", ram_wr_done_o, ram_wr_en_o);
        else pass_cnt++;
        step(1'b0, 8'h00, 1'b0);
        chk_cnt++;
        if (ram_wr_done_o !== 8'h00)
            $display("FAIL flush_width: done=%h want 00", ram_wr_done_o);
        else pass_cnt++;
        step(1'b1, 8'h5C, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk_cnt++;
        if (ram_wr_done_o !== 8'hFF)
            $display("FAIL flush_all: done=%h want ff", ram_wr_done_o);
        else pass_cnt++;
        step(1'b1, 8'h5A, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk_cnt++;
        if (ram_wr_done_o !== 8'h04)
            $display("FAIL flush_coincident_end: done=%h want 04", ram_wr_done_o);
        else pass_cnt++;
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_partial_word();
        logic [7:0] exp_done;
        exp_done = AUTO_FLUSH ? 8'h04 : 8'h00;
        step(1'b1, 8'h2C, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'hAA, 1'b1);
        chk_cnt++;
        if ({ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o} !== {8'h04, 8'h01, 8'h01, 4'h8})
            $display("FAIL partial_lane3: en=%h addr=%h data=%h be=%h want 04/01/01/8",
                     ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o);
        else pass_cnt++;
        step(1'b0, 8'h00, 1'b0);
        chk_cnt++;
        if ({ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o, ram_wr_done_o} !==
            {8'h04, 8'h01, 8'hAA, 4'h4, exp_done})
            $display("FAIL partial_lane2: en=%h addr=%h data=%h be=%h done=%h want 04/01/aa/4/%h",
                     ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o, ram_wr_done_o, exp_done);
        else pass_cnt++;
        step(1'b1, 8'h2C, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk_cnt++;
        if ({ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o, ram_wr_done_o} !==
            {8'h04, 8'h01, 8'h55, 4'h8, 8'h00})
            $display("FAIL partial_resume: en=%h addr=%h data=%h be=%h done=%h want 04/01/55/8/00",
                     ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o, ram_wr_done_o);
        else pass_cnt++;
        step(1'b0, 8'h00, 1'b0);
        chk_cnt++;
        if ({ram_wr_en_o, ram_wr_done_o} !== {8'h00, exp_done})
            $display("FAIL partial_end_done: en=%h done=%h want 00/%h", ram_wr_en_o, ram_wr_done_o, exp_done);
        else pass_cnt++;
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_unknown_opcode();
        logic [7:0] fq[$];
        fq = '{8'h77, 8'h2A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(fq, 1'b0);
        chk_cnt++;
        if ({reg_t0h_time_o, reg_t0s_time_o, reg_t1h_time_o, reg_t1s_time_o} !== {8'h10, 9'h020, 8'h01, 9'h1FF})
            $display("FAIL unknown_skip: got %h/%h/%h/%h want 10/020/01/1ff",
                     reg_t0h_time_o, reg_t0s_time_o, reg_t1h_time_o, reg_t1s_time_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        step(1'b1, 8'h2C, 1'b0);
        step(1'b1, 8'h12, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk_cnt++;
        if (ram_wr_en_o !== 8'h04)
            $display("FAIL rst_mid_pre: en=%h want 04", ram_wr_en_o);
        else pass_cnt++;
        #1 rst_n_i = 1'b0;
        #1;
        chk_cnt++;
        if ({ram_wr_en_o, ram_wr_addr_o, ram_wr_byte_en_o, reg_t0h_time_o, reg_t1s_time_o} !==
            {8'h00, 8'h00, 4'h0, 8'd16, 9'd60})
            $display("FAIL rst_mid_clear: en=%h addr=%h be=%h t0h=%0d t1s=%0d want 00/00/0/16/60",
                     ram_wr_en_o, ram_wr_addr_o, ram_wr_byte_en_o, reg_t0h_time_o, reg_t1s_time_o);
        else pass_cnt++;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_random_frames();
        logic [7:0] fq[$];
        logic [7:0] ops[6];
        int  n;
        bit  coinc;
        ops = '{8'h2A, 8'h3A, 8'h3C, 8'h2C, 8'h5A, 8'h5C};
        model_reset();
        obs_q.delete();
        exp_q.delete();
        mon_on = 1'b1;
        for (int f = 0; f < 60; f++) begin
            fq.delete();
            n = $urandom_range(0, 9);
            for (int i = 0; i < n; i++) begin
                if (i == 0) begin
                    if ($urandom_range(0, 7) < 6) fq.push_back(ops[$urandom_range(0, 5)]);
                    else                          fq.push_back(8'($urandom));
                end else if (i == 1 && fq[0] == 8'h3A) begin
                    fq.push_back(8'($urandom_range(0, 11)));
                end else begin
                    fq.push_back(8'($urandom));
                end
            end
            coinc = (n > 0) && ($urandom_range(0, 1) == 1);
            model_frame(fq, coinc);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, 1'b0);
                step(1'b1, fq[i], coinc && (i == n - 1));
            end
            if (!coinc) step(1'b0, 8'h00, 1'b1);
            repeat (3) step(1'b0, 8'h00, 1'b0);
            chk_cnt++;
            if (obs_q.size() != exp_q.size())
                $display("FAIL rand_event_count[frame %0d]: got %0d want %0d", f, obs_q.size(), exp_q.size());
            else pass_cnt++;
            for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
                chk_cnt++;
                if (obs_q[k].en !== exp_q[k].en || obs_q[k].done !== exp_q[k].done ||
                    (exp_q[k].en != 8'h00 && (obs_q[k].addr !== exp_q[k].addr ||
                     obs_q[k].data !== exp_q[k].data || obs_q[k].be !== exp_q[k].be)))
                    $display("FAIL rand_event[frame %0d ev %0d]: got en=%h done=%h addr=%h data=%h be=%h want en=%h done=%h addr=%h data=%h be=%h",
                             f, k, obs_q[k].en, obs_q[k].done, obs_q[k].addr, obs_q[k].data, obs_q[k].be,
                             exp_q[k].en, exp_q[k].done, exp_q[k].addr, exp_q[k].data, exp_q[k].be);
                else pass_cnt++;
            end
            chk_cnt++;
            if ({reg_t0h_time_o, reg_t0s_time_o, reg_t1h_time_o, reg_t1s_time_o} !== {m_t0h, m_t0s, m_t1h, m_t1s})
                $display("FAIL rand_timing[frame %0d]: got %h/%h/%h/%h want %h/%h/%h/%h", f,
                         reg_t0h_time_o, reg_t0s_time_o, reg_t1h_time_o, reg_t1s_time_o,
                         m_t0h, m_t0s, m_t1h, m_t1s);
            else pass_cnt++;
            obs_q.delete();
            exp_q.delete();
        end
        mon_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_conf();
        test_data_burst();
        test_chan_sel_flush();
        test_partial_word();
        test_unknown_opcode();
        test_reset_mid_frame();
        test_random_frames();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
